sequence_storage: RTL and testbench
===================================

# sequence_storage

Upstream stage of `sequence_translator`: collects classified dot/dash symbols from the key-press classifier and packs them into three 10-bit Morse codes. When the third character is committed, or on an early flush, it issues the packed 30-bit `sequences` word with a one-cycle `storage_sent` strobe. Each code holds five 2-bit symbol slots: `00` dot, `01` dash, `11` empty. An all-ones code (`10'h3FF`) marks an invalid or absent character, which the translator maps to null.

## Interface
- `IDLE_CYCLES`, default 50_000_000: idle cycles after the last symbol before an automatic character commit. Used only with `SEQ_STORAGE_AUTOCOMMIT_EN`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `dot` in 1: one-cycle pulse, append a dot symbol.
- `dash` in 1: one-cycle pulse, append a dash symbol.
- `char_end` in 1: one-cycle pulse, commit the current character.
- `flush` in 1: one-cycle pulse, send whatever is stored now.
- `sequences` out 30: packed codes; char 0 in [29:20], char 1 in [19:10], char 2 in [9:0].
- `storage_sent` out 1: one-cycle strobe; `sequences` is valid in the same cycle.
- `char_count` out 2: number of characters committed in the working buffer (0–2).

## Operation
- **Working state:** 30-bit buffer `work`, char index `ci` (0–2), symbol count `sc` (0–5), overflow flag `ov`. Reset, and every send, sets `work = 30'h3FFFFFFF`, `ci = 0`, `sc = 0`, `ov = 0`.
- **Symbol append:**
  - Exactly one of `dot`/`dash` high: write the symbol into slot `sc` of char `ci`. Slot 0 occupies the code MSBs ([9:8] of the 10-bit code).
  - Then `sc` increments.
  - `dot` and `dash` high together: ignored, no state change.
- **Overflow:** a symbol arriving with `sc == 5` sets `ov`. On commit, that character's code is forced to `10'h3FF`.
- **Commit** (`char_end`, or auto-commit):
  - `sc == 0`: no-op.
  - Otherwise the char is finalised; unused slots stay `11`. Then `sc = 0`, `ov = 0`, `ci` increments.
  - If the committed char was char 2, a send occurs.
- **Same-cycle symbol and `char_end`:** the symbol is appended first, then the character is committed.
- **Flush:**
  - The partial char is committed if `sc > 0`.
  - If at least one character is then committed, send; remaining chars stay `10'h3FF`.
  - Flush with an empty buffer does nothing.
  - `flush` together with `char_end` behaves as a single flush.
- **Send:** `sequences <= final work`, `storage_sent <= 1` for exactly one cycle, then the working state is cleared in the same edge.
- **Inputs during the strobe:** symbols arriving in the cycle `storage_sent` is high go into the fresh buffer; none are lost.
- **Output hold:** `sequences` holds its value until the next send.
- `char_count = ci`.

## Timing
- Reset values: `sequences = 30'h3FFFFFFF`, `storage_sent = 0`, `char_count = 0`.
- All outputs are registered.
- Latency: `storage_sent` rises in the cycle after the edge that samples the committing `char_end`/`flush` (one-cycle latency).
- Back-to-back sends are allowed; `storage_sent` may be high in consecutive cycles only if consecutive sends occur.
- Reset mid-character or mid-strobe discards the buffer immediately; no send is produced.
- Inputs are assumed synchronous to `clk`; debouncing and pulse shaping are upstream.

## Configuration
- **`SEQ_STORAGE_AUTOCOMMIT_EN` defined:**
  - An idle counter resets on each accepted symbol and counts while `sc > 0`.
  - On reaching `IDLE_CYCLES - 1`, the block performs a commit exactly as `char_end` would.
  - A same-cycle `char_end` counts as a single commit.
  - The counter is cleared by any commit, flush, send or reset.
- **Not defined:** no counter is built; commits come only from `char_end`/`flush`, and `IDLE_CYCLES` is unused.

## Test plan
- **SOS:** reset; dot×3, char_end; dash×3, char_end; dot×3, char_end → one `storage_sent` pulse with `sequences = {10'b0000001111, 10'b0101011111, 10'b0000001111}`; `char_count` returns to 0.
- **Overflow:** dash×6, char_end, then dot×3 + char_end twice → char 0 is `10'h3FF`, chars 1–2 are `10'b0000001111`.
- **Flush:** dash×3, char_end, dot + flush in the same cycle → `sequences = {10'b0101011111, 10'b0011111111, 10'h3FF}`. A second flush on the empty buffer → no pulse.
- **Back-to-back:** after the third char_end, feed dot in the `storage_sent` cycle → the next send's char 0 begins with `00`.
- **Reset mid-char:** dot×2, assert `rst` → all outputs at reset values; the following char_end with `sc = 0` → no effect.
- **Autocommit:** with `SEQ_STORAGE_AUTOCOMMIT_EN` and `IDLE_CYCLES = 8`: dot, wait 8 cycles → `char_count = 1` with no char_end; without the macro → `char_count` stays 0.

Source files
------------

// File: rtl/sequence_storage.sv
// sequence_storage
//   Collects dot/dash symbols from the key-press classifier and packs them into
//   three 10-bit Morse codes (five 2-bit slots each: 00 dot, 01 dash, 11 empty).
//   When the third character is committed, or on a flush of a non-empty buffer,
//   the packed 30-bit word is issued with a one-cycle o_storage_sent strobe.
//   A character that received more than five symbols is reported as 10'h3FF.
//
// Optional feature: define SEQ_STORAGE_AUTOCOMMIT_EN to build an idle timer that
//   commits the current character after IDLE_CYCLES quiet cycles. When the macro
//   is undefined, commits come only from i_char_end / i_flush.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_dot          one-cycle pulse, append dot
//   i_dash         one-cycle pulse, append dash (dot+dash together is ignored)
//   i_char_end     one-cycle pulse, commit current character
//   i_flush        one-cycle pulse, commit partial character and send
//   o_sequences    packed codes: char0 [29:20], char1 [19:10], char2 [9:0]
//   o_storage_sent one-cycle strobe, o_sequences valid in the same cycle
//   o_char_count   characters committed in the working buffer (0-2)
module sequence_storage #(
  parameter int IDLE_CYCLES = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dot,
  input  logic        i_dash,
  input  logic        i_char_end,
  input  logic        i_flush,
  output logic [29:0] o_sequences,
  output logic        o_storage_sent,
  output logic [1:0]  o_char_count
);

  if (IDLE_CYCLES < 2) begin : g_idle_chk
    $error("sequence_storage: IDLE_CYCLES must be at least 2");
  end

  logic [29:0] r_work;
  logic [1:0]  r_ci;
  logic [2:0]  r_sc;
  logic        r_ov;
  logic [29:0] r_sequences;
  logic        r_sent;

  logic [29:0] w_work;
  logic [1:0]  w_ci;
  logic [2:0]  w_sc;
  logic        w_ov;
  logic        w_send;
  logic        w_commit;
  logic        w_sym;
  logic [1:0]  w_sym_code;
  logic        w_auto;

  assign w_sym      = i_dot ^ i_dash;
  assign w_sym_code = {1'b0, i_dash};

`ifdef SEQ_STORAGE_AUTOCOMMIT_EN
  // Down-counter loaded on every accepted symbol; terminal count (zero) while a
  // character is in progress and no new symbol arrives triggers a commit.
  logic [31:0] r_idle;

  assign w_auto = (r_sc != 3'd0) && (r_idle == 32'd0) && !w_sym;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idle <= 32'(IDLE_CYCLES - 1);
    end else if (w_send || w_commit || i_flush || w_sym) begin
      r_idle <= 32'(IDLE_CYCLES - 1);
    end else if (r_sc != 3'd0 && r_idle != 32'd0) begin
      r_idle <= r_idle - 32'd1;
    end
  end
`else
  assign w_auto = 1'b0;
`endif

  // Next working state: append first, then commit, then decide on a send.
  always_comb begin
    w_work   = r_work;
    w_ci     = r_ci;
    w_sc     = r_sc;
    w_ov     = r_ov;
    w_send   = 1'b0;
    w_commit = 1'b0;

    if (w_sym) begin
      if (r_sc == 3'd5) begin
        w_ov = 1'b1;
      end else begin
        for (int c = 0; c < 3; c++) begin
          for (int s = 0; s < 5; s++) begin
            if (r_ci == 2'(c) && r_sc == 3'(s)) begin
              w_work[29 - 10*c - 2*s -: 2] = w_sym_code;
            end
          end
        end
        w_sc = r_sc + 3'd1;
      end
    end

    if ((i_char_end || i_flush || w_auto) && w_sc != 3'd0) begin
      w_commit = 1'b1;
      if (w_ov) begin
        for (int c = 0; c < 3; c++) begin
          if (r_ci == 2'(c)) begin
            w_work[29 - 10*c -: 10] = 10'h3FF;
          end
        end
      end
      w_sc = 3'd0;
      w_ov = 1'b0;
      if (r_ci == 2'd2) begin
        w_send = 1'b1;
      end else begin
        w_ci = r_ci + 2'd1;
      end
    end

    if (i_flush && w_ci != 2'd0) begin
      w_send = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_work      <= '1;
      r_ci        <= 2'd0;
      r_sc        <= 3'd0;
      r_ov        <= 1'b0;
      r_sequences <= '1;
      r_sent      <= 1'b0;
    end else if (w_send) begin
      r_sequences <= w_work;
      r_sent      <= 1'b1;
      r_work      <= '1;
      r_ci        <= 2'd0;
      r_sc        <= 3'd0;
      r_ov        <= 1'b0;
    end else begin
      r_sent      <= 1'b0;
      r_work      <= w_work;
      r_ci        <= w_ci;
      r_sc        <= w_sc;
      r_ov        <= w_ov;
    end
  end

  assign o_sequences    = r_sequences;
  assign o_storage_sent = r_sent;
  assign o_char_count   = r_ci;

endmodule

// File: tb/tb_sequence_storage.sv
module tb_sequence_storage;
  localparam int IDLE = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        dot, dash, char_end, flush;
  logic [29:0] sequences;
  logic        storage_sent;
  logic [1:0]  char_count;

  always #5 clk = ~clk;

  sequence_storage #(.IDLE_CYCLES(IDLE)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_dot          (dot),
    .i_dash         (dash),
    .i_char_end     (char_end),
    .i_flush        (flush),
    .o_sequences    (sequences),
    .o_storage_sent (storage_sent),
    .o_char_count   (char_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: list of symbols of the open character, list of finished codes.
  bit          m_sy[$];
  logic [9:0]  m_codes[$];
  logic [29:0] m_seq;
  bit          m_sent;
  int          m_idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_sy.delete();
    m_codes.delete();
    m_seq  = '1;
    m_sent = 1'b0;
    m_idle = 0;
  endtask

  task automatic m_step(input bit d, input bit da, input bit c, input bit f);
    bit          sym;
    bit          auto_c;
    logic [9:0]  code;
    logic [29:0] word;
    sym    = d ^ da;
    auto_c = 1'b0;
`ifdef SEQ_STORAGE_AUTOCOMMIT_EN
    auto_c = !sym && (m_sy.size() > 0) && (m_idle == IDLE - 1);
`endif
    if (sym) m_sy.push_back(da);
    m_sent = 1'b0;
    if ((c || f || auto_c) && m_sy.size() > 0) begin
      code = '1;
      if (m_sy.size() <= 5)
        for (int i = 0; i < m_sy.size(); i++) code[9 - 2*i -: 2] = {1'b0, m_sy[i]};
      m_codes.push_back(code);
      m_sy.delete();
    end
    if (m_codes.size() == 3 || (f && m_codes.size() > 0)) begin
      word = '1;
      for (int i = 0; i < m_codes.size(); i++) word[29 - 10*i -: 10] = m_codes[i];
      m_seq  = word;
      m_sent = 1'b1;
      m_codes.delete();
    end
    if (sym) m_idle = 0;
    else if (m_sy.size() > 0) m_idle++;
    else m_idle = 0;
  endtask

  task automatic cycle(input bit d, input bit da, input bit c, input bit f);
    @(negedge clk);
    dot = d; dash = da; char_end = c; flush = f;
    @(posedge clk);
    m_step(d, da, c, f);
    #1;
    chk("storage_sent", 32'(storage_sent), 32'(m_sent));
    chk("char_count", 32'(char_count), 32'(m_codes.size()));
    chk("sequences", 32'(sequences), 32'(m_seq));
  endtask

  task automatic do_reset();
    @(negedge clk);
    dot = 0; dash = 0; char_end = 0; flush = 0;
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_sequences", 32'(sequences), 32'h3FFF_FFFF);
    chk("rst_sent", 32'(storage_sent), 32'd0);
    chk("rst_char_count", 32'(char_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic sos();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
  endtask

  initial begin
    rst = 1'b1; dot = 0; dash = 0; char_end = 0; flush = 0;
    m_reset();
    #12;
    do_reset();

    // SOS
    sos();
    chk("sos_strobe", 32'(storage_sent), 32'd1);
    chk("sos_seq", 32'(sequences), 32'({10'b0000001111, 10'b0101011111, 10'b0000001111}));
    idle(2);

    // Overflow
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 0);
    end
    chk("ovf_seq", 32'(sequences), 32'({10'h3FF, 10'b0000001111, 10'b0000001111}));
    idle(2);

    // Flush with same-cycle dot, then flush on empty buffer
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 1);
    chk("flush_seq", 32'(sequences), 32'({10'b0101011111, 10'b0011111111, 10'h3FF}));
    cycle(0, 0, 0, 1);
    chk("flush_empty_no_pulse", 32'(storage_sent), 32'd0);
    cycle(1, 1, 1, 0);
    idle(2);

    // Back-to-back: dot during the strobe lands in the fresh buffer
    sos();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 1);
    chk("b2b_strobe", 32'(storage_sent), 32'd1);
    chk("b2b_char0", 32'(sequences[29:20]), 32'h0FF);
    idle(2);

    // Reset during strobe and mid-character
    sos();
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    do_reset();
    cycle(0, 0, 1, 0);
    chk("rst_then_char_end", 32'(char_count), 32'd0);

    // Idle timeout
    cycle(1, 0, 0, 0);
    idle(IDLE);
`ifdef SEQ_STORAGE_AUTOCOMMIT_EN
    chk("autocommit_count", 32'(char_count), 32'd1);
`else
    chk("autocommit_count", 32'(char_count), 32'd0);
`endif
    cycle(0, 0, 0, 1);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit d, da, c, f;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        r  = int'($urandom_range(0, 99));
        d  = (r < 25);
        da = (r >= 20 && r < 45);
        c  = ($urandom_range(0, 99) < 15);
        f  = ($urandom_range(0, 99) < 4);
        cycle(d, da, c, f);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
